// File: rtl/tv80_pkg.sv
// Shared TV80 definitions: flag bit layout, 8-bit ALU op codes, 16-bit op
// codes and the 16-bit sequencer state encoding.
package tv80_pkg;

   localparam int BIT_C = 0;
   localparam int BIT_N = 1;
   localparam int BIT_P = 2;
   localparam int BIT_X = 3;
   localparam int BIT_H = 4;
   localparam int BIT_Y = 5;
   localparam int BIT_Z = 6;
   localparam int BIT_S = 7;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_ADC = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_SBC = 4'b0011;

   typedef enum logic [1:0] {
      OP16_ADD  = 2'b00,
      OP16_ADC  = 2'b01,
      OP16_SBC  = 2'b10,
      OP16_RSVD = 2'b11
   } op16_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LO   = 2'b01,
      ST_HI   = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // The low pass of ADD16 needs no carry-in; every high pass chains it.
   function automatic logic [3:0] lo_alu_op(input op16_t op16);
      logic [3:0] code;
      code = ALU_ADD;
      if (op16 == OP16_ADC) code = ALU_ADC;
      if (op16 == OP16_SBC) code = ALU_SBC;
      return code;
   endfunction

   function automatic logic [3:0] hi_alu_op(input op16_t op16);
      return (op16 == OP16_SBC) ? ALU_SBC : ALU_ADC;
   endfunction

endpackage

// File: rtl/tv80_alu.sv
// Arithmetic group (ADD/ADC/SUB/SBC) of the TV80 8-bit ALU, with the Arith16
// and Z16 hooks used for 16-bit work. Other op codes pass BusA/F_In through.
module tv80_alu
   import tv80_pkg::*;
(
   input  logic [3:0] alu_op,
   input  logic       arith16,
   input  logic       z16,
   input  logic [7:0] busa,
   input  logic [7:0] busb,
   input  logic [7:0] f_in,
   output logic [7:0] q,
   output logic [7:0] f_out
);

   logic       sub;
   logic       cin;
   logic [7:0] bx;
   logic [4:0] sum_lo;
   logic [3:0] sum_mid;
   logic [1:0] sum_top;
   logic [7:0] q_v;

   always_comb begin
      sub     = alu_op[1];
      bx      = sub ? ~busb : busb;
      // Subtraction runs as A + ~B + ~borrow, so raw carries are inverted borrows.
      cin     = sub ^ (alu_op[0] & f_in[BIT_C]);
      sum_lo  = {1'b0, busa[3:0]} + {1'b0, bx[3:0]} + {4'b0000, cin};
      sum_mid = {1'b0, busa[6:4]} + {1'b0, bx[6:4]} + {3'b000, sum_lo[4]};
      sum_top = {1'b0, busa[7]} + {1'b0, bx[7]} + {1'b0, sum_mid[3]};
      q_v     = {sum_top[0], sum_mid[2:0], sum_lo[3:0]};

      q     = busa;
      f_out = f_in;
      if (alu_op[3:2] == 2'b00) begin
         q            = q_v;
         f_out[BIT_C] = sum_top[1] ^ sub;
         f_out[BIT_N] = sub;
         f_out[BIT_P] = sum_top[1] ^ sum_mid[3];
         f_out[BIT_X] = q_v[3];
         f_out[BIT_H] = sum_lo[4] ^ sub;
         f_out[BIT_Y] = q_v[5];
         f_out[BIT_S] = q_v[7];
         // With Z16 a zero high byte inherits Z from the low pass.
         if (q_v == 8'h00) f_out[BIT_Z] = z16 ? f_in[BIT_Z] : 1'b1;
         else              f_out[BIT_Z] = 1'b0;
         if (arith16) begin
            f_out[BIT_S] = f_in[BIT_S];
            f_out[BIT_Z] = f_in[BIT_Z];
            f_out[BIT_P] = f_in[BIT_P];
         end
      end
   end

endmodule

// File: rtl/tv80_alu16_seq.sv
// Drives the TV80 8-bit ALU through a low-byte then high-byte pass to run
// ADD HL,ss / ADC HL,ss / SBC HL,ss, chaining carry and zero through the flags.
module tv80_alu16_seq
   import tv80_pkg::*;
#(
   parameter int FLAG_C = BIT_C,
   parameter int FLAG_Z = BIT_Z,
   parameter int FLAG_S = BIT_S
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   input  logic [7:0]  flags_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [7:0]  flags_out,
   output logic [3:0]  alu_op,
   output logic        alu_arith16,
   output logic        alu_z16,
   output logic [7:0]  alu_busa,
   output logic [7:0]  alu_busb,
   output logic [7:0]  alu_f_in,
   input  logic [7:0]  alu_q,
   input  logic [7:0]  alu_f_out
);

   // Flags are chained opaquely, but the companion ALU assumes this layout.
   if (FLAG_C != BIT_C || FLAG_Z != BIT_Z || FLAG_S != BIT_S) begin : g_flag_map_check
      $error("tv80_alu16_seq: flag bit layout differs from tv80_pkg");
   end

   state_t     state;
   op16_t      op_reg;
   op16_t      op_in;
   logic [7:0] opa_hi_reg;
   logic [7:0] opb_hi_reg;
   logic       accept;

   assign op_in  = op16_t'(op);
   assign accept = start && (op_in != OP16_RSVD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_reg      <= OP16_ADD;
         opa_hi_reg  <= 8'h00;
         opb_hi_reg  <= 8'h00;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= 16'h0000;
         flags_out   <= 8'h00;
         alu_op      <= 4'h0;
         alu_arith16 <= 1'b0;
         alu_z16     <= 1'b0;
         alu_busa    <= 8'h00;
         alu_busb    <= 8'h00;
         alu_f_in    <= 8'h00;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (accept) begin
                  // Low byte goes straight to the ALU; only the high bytes wait.
                  state       <= ST_LO;
                  busy        <= 1'b1;
                  op_reg      <= op_in;
                  opa_hi_reg  <= opa[15:8];
                  opb_hi_reg  <= opb[15:8];
                  alu_op      <= lo_alu_op(op_in);
                  alu_arith16 <= (op_in == OP16_ADD);
                  alu_z16     <= 1'b0;
                  alu_busa    <= opa[7:0];
                  alu_busb    <= opb[7:0];
                  alu_f_in    <= flags_in;
               end else begin
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
                  alu_op      <= 4'h0;
                  alu_arith16 <= 1'b0;
                  alu_z16     <= 1'b0;
                  alu_busa    <= 8'h00;
                  alu_busb    <= 8'h00;
                  alu_f_in    <= 8'h00;
               end
            end
            ST_LO: begin
               // alu_f_in doubles as the low-pass flag register for the high pass.
               state        <= ST_HI;
               result[7:0]  <= alu_q;
               alu_f_in     <= alu_f_out;
               alu_op       <= hi_alu_op(op_reg);
               alu_z16      <= (op_reg != OP16_ADD);
               alu_busa     <= opa_hi_reg;
               alu_busb     <= opb_hi_reg;
            end
            ST_HI: begin
               state        <= ST_DONE;
               busy         <= 1'b0;
               done         <= 1'b1;
               result[15:8] <= alu_q;
               flags_out    <= alu_f_out;
               alu_op       <= 4'h0;
               alu_arith16  <= 1'b0;
               alu_z16      <= 1'b0;
               alu_busa     <= 8'h00;
               alu_busb     <= 8'h00;
               alu_f_in     <= 8'h00;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Directed bench for tv80_alu16_seq paired with tv80_alu: a vector table of
// 16-bit operations plus handshake, back-to-back and reset-abort sequences.
module tb_tv80_alu16_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [15:0] opa;
   logic [15:0] opb;
   logic [7:0]  flags_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [7:0]  flags_out;
   logic [3:0]  alu_op;
   logic        alu_arith16;
   logic        alu_z16;
   logic [7:0]  alu_busa;
   logic [7:0]  alu_busb;
   logic [7:0]  alu_f_in;
   logic [7:0]  alu_q;
   logic [7:0]  alu_f_out;

   always #5 clk = ~clk;

   tv80_alu u_alu (
      .alu_op  (alu_op),
      .arith16 (alu_arith16),
      .z16     (alu_z16),
      .busa    (alu_busa),
      .busb    (alu_busb),
      .f_in    (alu_f_in),
      .q       (alu_q),
      .f_out   (alu_f_out)
   );

   tv80_alu16_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .opa         (opa),
      .opb         (opb),
      .flags_in    (flags_in),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .flags_out   (flags_out),
      .alu_op      (alu_op),
      .alu_arith16 (alu_arith16),
      .alu_z16     (alu_z16),
      .alu_busa    (alu_busa),
      .alu_busb    (alu_busb),
      .alu_f_in    (alu_f_in),
      .alu_q       (alu_q),
      .alu_f_out   (alu_f_out)
   );

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  f;
      logic [15:0] res;
      logic [7:0]  fl;
      logic [3:0]  lo_op;
      logic [3:0]  hi_op;
      logic        a16;
      logic        z16_hi;
   } vec_t;

   localparam int NVEC = 8;
   vec_t vecs [NVEC];

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int done_seen;

   initial begin
      vecs[0] = '{2'b00, 16'h1234, 16'h0FFF, 8'hC4, 16'h2233, 8'hF4, 4'b0000, 4'b0001, 1'b1, 1'b0};
      vecs[1] = '{2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51, 4'b0001, 4'b0001, 1'b0, 1'b1};
      vecs[2] = '{2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E, 4'b0011, 4'b0011, 1'b0, 1'b1};
      vecs[3] = '{2'b10, 16'h0100, 16'h00FF, 8'h01, 16'h0000, 8'h42, 4'b0011, 4'b0011, 1'b0, 1'b1};
      vecs[4] = '{2'b10, 16'h0105, 16'h0005, 8'h00, 16'h0100, 8'h02, 4'b0011, 4'b0011, 1'b0, 1'b1};
      vecs[5] = '{2'b00, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h01, 4'b0000, 4'b0001, 1'b1, 1'b0};
      vecs[6] = '{2'b01, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 8'h94, 4'b0001, 4'b0001, 1'b0, 1'b1};
      vecs[7] = '{2'b10, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'hBB, 4'b0011, 4'b0011, 1'b0, 1'b1};

      reset = 1'b1; start = 1'b0; op = 2'b00;
      opa = 16'hFFFF; opb = 16'hFFFF; flags_in = 8'hFF;
      tick();
      tick();
      check("reset_busy_done", {30'd0, busy, done}, 32'd0);
      check("reset_result", {16'd0, result}, 32'd0);
      check("reset_flags", {24'd0, flags_out}, 32'd0);
      check("reset_alu_bus", {alu_busa, alu_busb, alu_f_in, alu_op, alu_arith16, alu_z16, 2'b00}, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < NVEC; i++) begin
         op = vecs[i].op; opa = vecs[i].a; opb = vecs[i].b; flags_in = vecs[i].f;
         start = 1'b1;
         tick();
         start = 1'b0; opa = 16'hA5C3; opb = 16'h3C5A; flags_in = 8'hAA;
         check("lo_busy", {31'd0, busy}, 32'd1);
         check("lo_alu_op", {28'd0, alu_op}, {28'd0, vecs[i].lo_op});
         check("lo_operands", {8'd0, alu_busa, alu_busb, alu_f_in},
               {8'd0, vecs[i].a[7:0], vecs[i].b[7:0], vecs[i].f});
         check("lo_a16_z16", {30'd0, alu_arith16, alu_z16}, {30'd0, vecs[i].a16, 1'b0});
         tick();
         check("hi_busy_done", {30'd0, busy, done}, 32'd2);
         check("hi_alu_op", {28'd0, alu_op}, {28'd0, vecs[i].hi_op});
         check("hi_operands", {16'd0, alu_busa, alu_busb}, {16'd0, vecs[i].a[15:8], vecs[i].b[15:8]});
         check("hi_a16_z16", {30'd0, alu_arith16, alu_z16}, {30'd0, vecs[i].a16, vecs[i].z16_hi});
         tick();
         check("done_pulse", {30'd0, busy, done}, 32'd1);
         check("result", {16'd0, result}, {16'd0, vecs[i].res});
         check("flags_out", {24'd0, flags_out}, {24'd0, vecs[i].fl});
         check("done_alu_idle", {alu_busa, alu_busb, alu_f_in, alu_op, alu_arith16, alu_z16, 2'b00}, 32'd0);
         $display("vec %0d op=%b a=%h b=%h f=%h -> result=%h flags=%h", i, vecs[i].op,
                  vecs[i].a, vecs[i].b, vecs[i].f, result, flags_out);
         tick();
         check("idle_done_low", {30'd0, busy, done}, 32'd0);
         check("result_hold", {16'd0, result}, {16'd0, vecs[i].res});
      end

      // start held high through LO and HI: one operation only
      op = 2'b00; opa = 16'h1234; opb = 16'h0FFF; flags_in = 8'hC4; start = 1'b1;
      tick();
      tick();
      check("held_hi_op", {28'd0, alu_op}, 32'd1);
      tick();
      check("held_done", {30'd0, busy, done}, 32'd1);
      start = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done || busy) done_seen++;
      end
      check("held_single_op", done_seen, 0);
      $display("seq held-start result=%h flags=%h", result, flags_out);

      // start accepted in the DONE cycle
      op = 2'b00; opa = 16'h1234; opb = 16'h0FFF; flags_in = 8'hC4; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("b2b_first_done", {30'd0, busy, done}, 32'd1);
      check("b2b_first_result", {16'd0, result}, 32'h2233);
      op = 2'b10; opa = 16'h8000; opb = 16'h0001; flags_in = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_second_lo", {26'd0, busy, done, alu_op}, {26'd0, 1'b1, 1'b0, 4'b0011});
      tick();
      check("b2b_second_hi", {30'd0, busy, done}, 32'd2);
      tick();
      check("b2b_second_done", {30'd0, busy, done}, 32'd1);
      check("b2b_second_result", {8'd0, result, flags_out}, {8'd0, 16'h7FFF, 8'h3E});
      $display("seq back-to-back result=%h flags=%h", result, flags_out);
      tick();

      // reserved op is ignored
      op = 2'b11; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
      tick();
      start = 1'b0;
      done_seen = 0;
      if (busy || done) done_seen++;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (busy || done) done_seen++;
      end
      check("rsvd_ignored", done_seen, 0);
      check("rsvd_result_hold", {16'd0, result}, 32'h7FFF);
      $display("seq reserved op busy=%b done=%b", busy, done);

      // reset during HI aborts the operation
      op = 2'b01; opa = 16'h7FFF; opb = 16'h0001; flags_in = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort_in_hi", {30'd0, busy, done}, 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_idle", {30'd0, busy, done}, 32'd0);
      check("abort_result", {8'd0, result, flags_out}, 32'd0);
      check("abort_alu_bus", {alu_busa, alu_busb, alu_f_in, alu_op, alu_arith16, alu_z16, 2'b00}, 32'd0);
      done_seen = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done || busy) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      $display("seq reset-abort result=%h busy=%b done=%b", result, busy, done);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tv80_alu16_seq.md
Name: tv80_alu16_seq

Overview:
- Sequencer that drives the TV80 8-bit ALU to execute the 16-bit ops ADD HL,ss / ADC HL,ss / SBC HL,ss.
- Runs as two byte passes: low byte first, then high byte with the carry chained through the flags.
- It is the initiator side of the ALU interface: it supplies ALU_Op/BusA/BusB/F_In/Arith16/Z16 and captures Q/F_Out.
- Sits beside the ALU in the CPU datapath, replacing microcode-driven 16-bit sequencing.

Parameters:
- FLAG_C, 0, bit index of carry in the flag byte.
- FLAG_Z, 6, bit index of zero in the flag byte.
- FLAG_S, 7, bit index of sign; remaining flag positions are taken from the shared package.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- op  in  2  operation: 00 ADD16, 01 ADC16, 10 SBC16, 11 reserved.
- opa  in  16  operand A (HL).
- opb  in  16  operand B (ss).
- flags_in  in  8  F register at start.
- busy  out  1  high in LO and HI.
- done  out  1  one-cycle pulse when result is valid.
- result  out  16  registered 16-bit result.
- flags_out  out  8  registered final flags.
- alu_op  out  4  to ALU ALU_Op.
- alu_arith16  out  1  to ALU Arith16.
- alu_z16  out  1  to ALU Z16.
- alu_busa  out  8  to ALU BusA.
- alu_busb  out  8  to ALU BusB.
- alu_f_in  out  8  to ALU F_In.
- alu_q  in  8  from ALU Q.
- alu_f_out  in  8  from ALU F_Out.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset clears every output to 0 (result, flags_out, done, busy, all alu_* outputs) and sets state IDLE.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: start with op!=11 latches opa, opb, flags_in and op, then goes to LO. start with op==11 is ignored: no state change, no done.
  - LO (1 cycle): alu_busa=A[7:0], alu_busb=B[7:0], alu_f_in=latched flags.
    - alu_op: 0000 for ADD16, 0001 for ADC16, 0011 for SBC16.
    - alu_arith16=1 for ADD16, else 0; alu_z16=0.
    - At the clock edge, capture alu_q into result[7:0] and alu_f_out into a low-flag register. Next state HI.
  - HI (1 cycle): alu_busa=A[15:8], alu_busb=B[15:8], alu_f_in=low-flag register.
    - alu_op: 0001 for ADD16/ADC16, 0011 for SBC16.
    - alu_arith16 as in LO; alu_z16=1 for ADC16/SBC16, else 0.
    - At the clock edge, capture alu_q into result[15:8] and alu_f_out into flags_out. Next state DONE.
  - DONE (1 cycle): done=1. A start here is accepted exactly as in IDLE (back-to-back, goes to LO); otherwise go to IDLE.
- In IDLE and DONE, all alu_* outputs are 0.
- Latency: start sampled at edge N; LO in cycle N+1, HI in N+2, done=1 in N+3.
- result and flags_out hold their values until the next capture.
- Flag semantics follow from the ALU:
  - ADD16: S/Z/P preserved from flags_in; H from bit 11; C from bit 15; N=0; X/Y from result[11]/[13].
  - ADC16/SBC16: Z=1 only if the full 16-bit result is zero (via Z16 chaining); S, V, C, H come from the high pass.
- start while busy is ignored.
- Reset mid-operation aborts: IDLE, no done, result cleared.
- Operand inputs may change after start without effect.

Decomposition:
- Shared package tv80_pkg holds:
  - flag bit indices;
  - ALU op encodings (ALU_ADD=0000, ALU_ADC=0001, ALU_SUB=0010, ALU_SBC=0011);
  - the 2-bit op16 encodings and the FSM state enum.
- No sub-module. The ALU is instantiated alongside, not inside; the bench instantiates tv80_alu plus this block.

Test Plan:
- ADD16, opa=0x1234, opb=0x0FFF, flags_in=0xC4 -> result=0x2233, flags_out=0xF4, done exactly 3 cycles after start, busy high in 2 cycles.
- ADC16, opa=0xFFFF, opb=0x0000, flags_in=0x01 -> result=0x0000, flags_out=0x51 (Z=1, H=1, C=1, V=0).
- SBC16, opa=0x8000, opb=0x0001, flags_in=0x00 -> result=0x7FFF, flags_out=0x3E (V=1, N=1, H=1, C=0).
- Z16 chaining:
  - SBC16, 0x0100-0x00FF, flags_in=0x01 -> result=0x0000, Z=1, C=0.
  - SBC16, 0x0105-0x0005, flags_in=0x00 -> result=0x0100, Z=0 (low byte zero alone does not set Z).
- Handshake:
  - start held high through LO/HI -> only one operation runs.
  - start in the DONE cycle -> second op enters LO the next cycle, done again 3 cycles later.
  - op=11 -> no busy, no done.
- Reset asserted during HI -> next cycle IDLE, busy=0, done=0, result=0x0000; no done pulse follows.
